// File: rtl/img_proc_pkg.sv
// img_proc_pkg: shared mode codes, luminance coefficients and threshold default
// for the image_filter_pipe colour-effect stage.
package img_proc_pkg;

    typedef enum logic [2:0] {
        MODE_PASS   = 3'd0,
        MODE_GRAY   = 3'd1,
        MODE_RED    = 3'd2,
        MODE_GREEN  = 3'd3,
        MODE_BLUE   = 3'd4,
        MODE_INVERT = 3'd5,
        MODE_BINARY = 3'd6,
        MODE_RSVD   = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_FIN
    } div_state_e;

    // Coefficients sum to 256 so that white maps to full-scale luminance.
    localparam int unsigned      COEF_W     = 8;
    localparam logic [COEF_W-1:0] COEF_R    = 8'd77;
    localparam logic [COEF_W-1:0] COEF_G    = 8'd150;
    localparam logic [COEF_W-1:0] COEF_B    = 8'd29;
    localparam int unsigned      LUMA_SHIFT = 8;

    function automatic int unsigned default_thresh(input int unsigned gray_w);
        return 32'd1 << (gray_w - 1);
    endfunction

endpackage

// File: rtl/image_filter_pipe_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle.
// A start while busy discards the running division and reloads the operands.
module seq_divider
    import img_proc_pkg::*;
#(
    parameter int unsigned DVD_W = 27,
    parameter int unsigned DSR_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DSR_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);
    localparam int unsigned STEP_W = $clog2(DVD_W + 1);

    div_state_e        state, state_n;
    logic [STEP_W-1:0] step;
    logic [DVD_W-1:0]  q;
    logic [DSR_W-1:0]  rem;
    logic [DSR_W-1:0]  dsr;
    logic [DSR_W:0]    shifted;
    logic [DSR_W:0]    diff;
    logic              fits;

    always_comb begin
        shifted = {rem, q[DVD_W-1]};
        diff    = shifted - {1'b0, dsr};
        fits    = (shifted >= {1'b0, dsr});
        state_n = state;
        if (start) begin
            state_n = DIV_RUN;
        end else begin
            case (state)
                DIV_RUN: if (step == STEP_W'(DVD_W - 1)) state_n = DIV_FIN;
                DIV_FIN: state_n = DIV_IDLE;
                default: state_n = state;
            endcase
        end
        busy = (state != DIV_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step     <= '0;
            q        <= '0;
            rem      <= '0;
            dsr      <= '0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= (state == DIV_FIN) && !start;
            if (start) begin
                step <= '0;
                q    <= dividend;
                rem  <= '0;
                dsr  <= divisor;
            end else if (state == DIV_RUN) begin
                step <= step + STEP_W'(1);
                q    <= {q[DVD_W-2:0], fits};
                rem  <= fits ? diff[DSR_W-1:0] : shifted[DSR_W-1:0];
            end
            if (state == DIV_FIN && !start) quotient <= q;
        end
    end

endmodule

// File: rtl/image_filter_pipe.sv
// image_filter_pipe: 3-stage luminance/colour-effect pipeline with per-frame mode latch.
// Define IMG_PROC_AUTO_THRESH_EN to build frame-mean measurement and auto threshold.
module image_filter_pipe
    import img_proc_pkg::*;
#(
    parameter int unsigned CH_W   = 4,
    parameter int unsigned GRAY_W = 8,
    parameter int unsigned CNT_W  = 19
) (
    input  logic                vga_clk,
    input  logic                rst,
    input  logic                process_en,
    input  logic [2:0]          mode,
    input  logic [GRAY_W-1:0]   thresh_manual,
    input  logic                thresh_auto,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic                in_eof,
    input  logic [3*CH_W-1:0]   in_data,
    output logic                out_valid,
    output logic                out_sof,
    output logic [3*CH_W-1:0]   out_data,
    output logic [GRAY_W-1:0]   frame_mean
);
    localparam int unsigned       PIX_W   = 3 * CH_W;
    localparam int unsigned       PROD_W  = GRAY_W + COEF_W;
    localparam int unsigned       SUM_W   = PROD_W + 2;
    localparam int unsigned       ACC_W   = GRAY_W + CNT_W;
    localparam logic [GRAY_W-1:0] THR_DEF = GRAY_W'(default_thresh(GRAY_W));

    function automatic logic [GRAY_W-1:0] expand(input logic [CH_W-1:0] c);
        logic [GRAY_W-1:0] e;
        for (int unsigned i = 0; i < GRAY_W; i++) e[GRAY_W-1-i] = c[CH_W-1-(i % CH_W)];
        return e;
    endfunction

    logic              frame_start;
    mode_e             eff_mode, cap_mode;
    logic [GRAY_W-1:0] thr, cap_thr;
    logic [GRAY_W-1:0] exp_r, exp_g, exp_b;

    logic              s1_valid, s1_sof, s1_eof;
    logic [PIX_W-1:0]  s1_data;
    logic [PROD_W-1:0] s1_pr, s1_pg, s1_pb;
    mode_e             s1_mode;
    logic [GRAY_W-1:0] s1_thr;

    logic              s2_valid, s2_sof, s2_eof;
    logic [PIX_W-1:0]  s2_data;
    logic [GRAY_W-1:0] s2_gray;
    mode_e             s2_mode;
    logic [GRAY_W-1:0] s2_thr;

    logic [SUM_W-1:0]  luma_sum;
    logic [CH_W-1:0]   tint;
    logic [PIX_W-1:0]  mux_data;

    assign frame_start = in_valid && in_sof;
    assign exp_r = expand(in_data[PIX_W-1 -: CH_W]);
    assign exp_g = expand(in_data[2*CH_W-1 -: CH_W]);
    assign exp_b = expand(in_data[CH_W-1:0]);

    always_comb begin
        cap_mode = process_en ? mode_e'(mode) : MODE_PASS;
`ifdef IMG_PROC_AUTO_THRESH_EN
        cap_thr  = thresh_auto ? frame_mean : thresh_manual;
`else
        cap_thr  = thresh_manual;
`endif
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            eff_mode <= MODE_PASS;
            thr      <= THR_DEF;
        end else if (frame_start) begin
            eff_mode <= cap_mode;
            thr      <= cap_thr;
        end
    end

    // Mode/threshold travel with each pixel so the sof pixel sees its own frame's settings.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_data  <= '0;
            s1_pr    <= '0;
            s1_pg    <= '0;
            s1_pb    <= '0;
            s1_mode  <= MODE_PASS;
            s1_thr   <= THR_DEF;
        end else begin
            s1_valid <= in_valid;
            s1_sof   <= in_valid && in_sof;
            s1_eof   <= in_valid && in_eof;
            s1_data  <= in_data;
            s1_pr    <= PROD_W'(exp_r) * PROD_W'(COEF_R);
            s1_pg    <= PROD_W'(exp_g) * PROD_W'(COEF_G);
            s1_pb    <= PROD_W'(exp_b) * PROD_W'(COEF_B);
            s1_mode  <= frame_start ? cap_mode : eff_mode;
            s1_thr   <= frame_start ? cap_thr : thr;
        end
    end

    assign luma_sum = SUM_W'(s1_pr) + SUM_W'(s1_pg) + SUM_W'(s1_pb);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eof   <= 1'b0;
            s2_data  <= '0;
            s2_gray  <= '0;
            s2_mode  <= MODE_PASS;
            s2_thr   <= THR_DEF;
        end else begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eof   <= s1_eof;
            s2_data  <= s1_data;
            s2_gray  <= GRAY_W'(luma_sum >> LUMA_SHIFT);
            s2_mode  <= s1_mode;
            s2_thr   <= s1_thr;
        end
    end

    always_comb begin
        tint     = s2_gray[GRAY_W-1 -: CH_W];
        mux_data = s2_data;
        case (s2_mode)
            MODE_GRAY:   mux_data = {tint, tint, tint};
            MODE_RED:    mux_data = {tint, {(2*CH_W){1'b0}}};
            MODE_GREEN:  mux_data = {{CH_W{1'b0}}, tint, {CH_W{1'b0}}};
            MODE_BLUE:   mux_data = {{(2*CH_W){1'b0}}, tint};
            MODE_INVERT: mux_data = ~s2_data;
            MODE_BINARY: mux_data = (s2_gray >= s2_thr) ? '1 : '0;
            default:     mux_data = s2_data;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= s2_valid;
            out_sof   <= s2_sof;
            out_data  <= mux_data;
        end
    end

`ifdef IMG_PROC_AUTO_THRESH_EN
    logic [ACC_W-1:0] acc_sum, snap_sum;
    logic [CNT_W-1:0] acc_cnt, snap_cnt;
    logic             div_start, div_busy, div_done;
    logic [ACC_W-1:0] div_quot;
    logic             unused_auto;

    // Snapshot includes the pixel currently in stage 2, so eof lands in its own frame.
    always_comb begin
        if (s2_sof) begin
            snap_sum = ACC_W'(s2_gray);
            snap_cnt = CNT_W'(1);
        end else begin
            snap_sum = acc_sum + ACC_W'(s2_gray);
            snap_cnt = acc_cnt + CNT_W'(1);
        end
        div_start = s2_valid && s2_eof && (snap_cnt != '0);
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            acc_sum <= '0;
            acc_cnt <= '0;
        end else if (s2_valid) begin
            acc_sum <= snap_sum;
            acc_cnt <= snap_cnt;
        end
    end

    seq_divider #(
        .DVD_W (ACC_W),
        .DSR_W (CNT_W)
    ) u_div (
        .clk      (vga_clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (snap_sum),
        .divisor  (snap_cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            frame_mean <= THR_DEF;
        end else if (div_done) begin
            frame_mean <= div_quot[GRAY_W-1:0];
        end
    end

    assign unused_auto = ^{div_busy, div_quot[ACC_W-1:GRAY_W]};
`else
    logic unused_auto;

    assign frame_mean  = THR_DEF;
    assign unused_auto = ^{thresh_auto, s2_eof};
`endif

endmodule

// File: tb/tb_image_filter_pipe.sv
// tb_image_filter_pipe: directed vectors with hand-computed pixels, checked 3 cycles later.
// Auto-threshold vectors are selected by IMG_PROC_AUTO_THRESH_EN.
module tb_image_filter_pipe;

    logic        vga_clk = 1'b0;
    logic        rst = 1'b1;
    logic        process_en = 1'b1;
    logic [2:0]  mode = 3'd0;
    logic [7:0]  thresh_manual = 8'h80;
    logic        thresh_auto = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic [11:0] in_data = '0;
    logic        out_valid, out_sof;
    logic [11:0] out_data;
    logic [7:0]  frame_mean;

    int n_cmp = 0;
    int n_bad = 0;
    int px_id = 0;

    typedef struct {
        logic        v;
        logic        s;
        logic [11:0] d;
        int          id;
    } exp_t;

    exp_t exp_q[$];

    image_filter_pipe #(
        .CH_W   (4),
        .GRAY_W (8),
        .CNT_W  (19)
    ) dut (
        .vga_clk       (vga_clk),
        .rst           (rst),
        .process_en    (process_en),
        .mode          (mode),
        .thresh_manual (thresh_manual),
        .thresh_auto   (thresh_auto),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .in_eof        (in_eof),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_sof       (out_sof),
        .out_data      (out_data),
        .frame_mean    (frame_mean)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One pixel slot; the pixel driven two calls earlier is visible at the outputs afterwards.
    task automatic step(input logic v, input logic s, input logic e,
                        input logic [11:0] d, input logic [11:0] x);
        exp_t ex;
        in_valid = v;
        in_sof   = s;
        in_eof   = e;
        in_data  = d;
        exp_q.push_back('{v: v, s: v && s, d: x, id: px_id});
        px_id++;
        @(posedge vga_clk);
        #1;
        if (exp_q.size() >= 3) begin
            ex = exp_q.pop_front();
            check($sformatf("px%0d_valid", ex.id), 32'(out_valid), 32'(ex.v));
            if (ex.v) begin
                check($sformatf("px%0d_sof", ex.id), 32'(out_sof), 32'(ex.s));
                check($sformatf("px%0d_data", ex.id), 32'(out_data), 32'(ex.d));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge vga_clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_sof", 32'(out_sof), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_mean", 32'(frame_mean), 32'h80);
        rst = 1'b0;

        // RED then GRAY on 12'hF00 (gray 8'h4C); leading bubble pins the 3-cycle latency.
        idle(1);
        mode = 3'd2;
        step(1, 1, 0, 12'hF00, 12'h400);
        step(1, 0, 1, 12'hF00, 12'h400);
        idle(1);
        mode = 3'd1;
        step(1, 1, 0, 12'hF00, 12'h444);
        step(1, 0, 0, 12'h0F0, 12'h999);
        step(1, 0, 1, 12'h00F, 12'h111);
        mode = 3'd3;
        step(1, 1, 1, 12'h0F0, 12'h090);
        mode = 3'd4;
        step(1, 1, 1, 12'h00F, 12'h001);
        idle(2);

        // INVERT, process_en override and reserved code
        mode = 3'd5;
        step(1, 1, 1, 12'h123, 12'hEDC);
        process_en = 1'b0;
        step(1, 1, 0, 12'h123, 12'h123);
        process_en = 1'b1;
        step(1, 0, 1, 12'h456, 12'h456);
        mode = 3'd7;
        step(1, 1, 1, 12'h123, 12'h123);

        // BINARY with manual threshold, including the equality boundary
        mode = 3'd6;
        thresh_manual = 8'h80;
        step(1, 1, 0, 12'hFFF, 12'hFFF);
        step(1, 0, 0, 12'h000, 12'h000);
        thresh_manual = 8'h00;
        step(1, 0, 0, 12'h888, 12'hFFF);
        step(1, 0, 1, 12'h777, 12'h000);
        thresh_manual = 8'h88;
        step(1, 1, 1, 12'h888, 12'hFFF);
        thresh_manual = 8'h89;
        step(1, 1, 1, 12'h888, 12'h000);
        idle(3);

`ifdef IMG_PROC_AUTO_THRESH_EN
        mode = 3'd0;
        step(1, 1, 0, 12'h888, 12'h888);
        step(1, 0, 0, 12'h888, 12'h888);
        step(1, 0, 0, 12'h888, 12'h888);
        step(1, 0, 1, 12'h888, 12'h888);
        idle(40);
        check("auto_mean", 32'(frame_mean), 32'h88);
        mode = 3'd6;
        thresh_auto = 1'b1;
        thresh_manual = 8'hFF;
        step(1, 1, 0, 12'h888, 12'hFFF);
        step(1, 0, 1, 12'h777, 12'h000);
        thresh_auto = 1'b0;
        idle(3);
`else
        mode = 3'd6;
        thresh_auto = 1'b1;
        thresh_manual = 8'h90;
        step(1, 1, 0, 12'h888, 12'h000);
        step(1, 0, 1, 12'hFFF, 12'hFFF);
        thresh_manual = 8'h70;
        step(1, 1, 1, 12'h777, 12'hFFF);
        thresh_auto = 1'b0;
        idle(3);
        check("fixed_mean", 32'(frame_mean), 32'h80);
`endif

        // Mid-frame mode change stays pass-through; bubble shows up as an out_valid gap
        mode = 3'd0;
        step(1, 1, 0, 12'h0F0, 12'h0F0);
        step(1, 0, 0, 12'h0F0, 12'h0F0);
        step(1, 0, 0, 12'h0F0, 12'h0F0);
        step(1, 0, 0, 12'h0F0, 12'h0F0);
        mode = 3'd1;
        step(1, 0, 0, 12'h0F0, 12'h0F0);
        step(1, 0, 0, 12'h00F, 12'h00F);
        idle(1);
        step(1, 0, 1, 12'h0F0, 12'h0F0);
        step(1, 1, 1, 12'h0F0, 12'h999);
        idle(3);

        // Reset while streaming an INVERT frame
        mode = 3'd5;
        step(1, 1, 0, 12'h123, 12'hEDC);
        step(1, 0, 0, 12'h123, 12'hEDC);
        rst = 1'b1;
        in_valid = 1'b1;
        in_sof = 1'b0;
        in_data = 12'h123;
        @(posedge vga_clk);
        #1;
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_mean", 32'(frame_mean), 32'h80);
        rst = 1'b0;
        exp_q.delete();
        mode = 3'd1;
        step(1, 0, 0, 12'h0F0, 12'h0F0);
        step(1, 0, 0, 12'h123, 12'h123);
        step(1, 0, 1, 12'h0F0, 12'h0F0);
        idle(1);
        step(1, 1, 1, 12'h0F0, 12'h999);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
